input_conditioner: RTL and testbench

- Front-end stage between the board pins (switches, buttons, external input pins) and the digital-input peripheral on the peripheral bus.
- Synchronizes all asynchronous pin inputs into the clk domain and debounces switches and buttons.
- Generates one-cycle button edge pulses and sticky press flags with write-1-to-clear, so software never sees metastable or bouncing values.

---
 rtl/input_conditioner_pkg.sv | 11 +
 rtl/input_conditioner_debounce_bit.sv | 48 ++++
 rtl/input_conditioner.sv | 73 +++++++
 tb/tb_input_conditioner.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/input_conditioner_pkg.sv
// input_conditioner_pkg: board-level constants shared by the input front-end
//    N_SW, N_BTN, N_IPIN : pin group widths
//    DEBOUNCE_DEFAULT    : stable cycles before a debounced output changes (10 ms at 100 MHz)
//    CLK_FREQ_HZ         : board clock frequency
package input_conditioner_pkg;
   localparam int N_SW             = 16;
   localparam int N_BTN            = 5;
   localparam int N_IPIN           = 4;
   localparam int DEBOUNCE_DEFAULT = 1_000_000;
   localparam int CLK_FREQ_HZ      = 100_000_000;
endpackage

// File: rtl/input_conditioner_debounce_bit.sv
// debounce_bit: synchronizer chain, stability counter and stable register for one pin
//    clk, rst_n : clock, asynchronous active-low reset
//    din        : raw asynchronous input
//    db         : debounced level
//    db_next    : level db takes on the next edge, used for same-edge pulse generation
module debounce_bit
   import input_conditioner_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT,
   parameter int SYNC_STAGES     = 2
) (
   input  logic clk,
   input  logic rst_n,
   input  logic din,
   output logic db,
   output logic db_next
);
   localparam int CW = $clog2(DEBOUNCE_CYCLES);
   localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);
   logic [SYNC_STAGES-1:0] sync_q, sync_d;
   logic [CW-1:0]          cnt_q, cnt_d;
   logic                   stable_q, stable_d;
   logic                   sync;
   always_comb begin
      sync_d   = {sync_q[SYNC_STAGES-2:0], din};
      sync     = sync_q[SYNC_STAGES-1];
      stable_d = stable_q;
      cnt_d    = '0;
      // any cycle back at the stable value leaves cnt_d at 0, restarting the count
      if (sync != stable_q) begin
         if (cnt_q == CNT_MAX) stable_d = sync;
         else cnt_d = cnt_q + 1'b1;
      end
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q   <= '0;
         cnt_q    <= '0;
         stable_q <= 1'b0;
      end else begin
         sync_q   <= sync_d;
         cnt_q    <= cnt_d;
         stable_q <= stable_d;
      end
   end
   assign db      = stable_q;
   assign db_next = stable_d;
endmodule

// File: rtl/input_conditioner.sv
// input_conditioner: synchronizes and debounces board pins ahead of the digital-input peripheral
//    clk, rst_n : 100 MHz clock, asynchronous active-low reset
//    sw, btn    : raw switches / buttons, debounced onto sw_db / btn_db
//    ipin       : raw external pins, synchronized only onto ipin_sync
//    btn_clr    : write-1-to-clear for btn_latch
//    btn_rise, btn_fall : one-cycle pulses on debounced button edges
//    btn_latch  : sticky press flags
module input_conditioner
   import input_conditioner_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT,
   parameter int SYNC_STAGES     = 2
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [N_SW-1:0]   sw,
   input  logic [N_BTN-1:0]  btn,
   input  logic [N_IPIN-1:0] ipin,
   input  logic [N_BTN-1:0]  btn_clr,
   output logic [N_SW-1:0]   sw_db,
   output logic [N_BTN-1:0]  btn_db,
   output logic [N_IPIN-1:0] ipin_sync,
   output logic [N_BTN-1:0]  btn_rise,
   output logic [N_BTN-1:0]  btn_fall,
   output logic [N_BTN-1:0]  btn_latch
);
   logic [N_SW-1:0]                   sw_db_next;
   logic [N_BTN-1:0]                  btn_db_next;
   logic [SYNC_STAGES-1:0][N_IPIN-1:0] ipin_q, ipin_d;
   logic [N_BTN-1:0]                  btn_rise_q, btn_rise_d;
   logic [N_BTN-1:0]                  btn_fall_q, btn_fall_d;
   logic [N_BTN-1:0]                  btn_latch_q, btn_latch_d;

   for (genvar i = 0; i < N_SW; i++) begin : g_sw
      debounce_bit #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .SYNC_STAGES(SYNC_STAGES)) u_db (
         .clk(clk), .rst_n(rst_n), .din(sw[i]), .db(sw_db[i]), .db_next(sw_db_next[i])
      );
   end

   for (genvar i = 0; i < N_BTN; i++) begin : g_btn
      debounce_bit #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .SYNC_STAGES(SYNC_STAGES)) u_db (
         .clk(clk), .rst_n(rst_n), .din(btn[i]), .db(btn_db[i]), .db_next(btn_db_next[i])
      );
   end

   // pulses are derived from the debouncer's next value so they register on the
   // same edge btn_db changes; set takes priority over clear in the sticky flag
   always_comb begin
      ipin_d      = {ipin_q[SYNC_STAGES-2:0], ipin};
      btn_rise_d  = btn_db_next & ~btn_db;
      btn_fall_d  = ~btn_db_next & btn_db;
      btn_latch_d = btn_rise_d | (btn_latch_q & ~btn_clr);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ipin_q      <= '0;
         btn_rise_q  <= '0;
         btn_fall_q  <= '0;
         btn_latch_q <= '0;
      end else begin
         ipin_q      <= ipin_d;
         btn_rise_q  <= btn_rise_d;
         btn_fall_q  <= btn_fall_d;
         btn_latch_q <= btn_latch_d;
      end
   end

   assign ipin_sync = ipin_q[SYNC_STAGES-1];
   assign btn_rise  = btn_rise_q;
   assign btn_fall  = btn_fall_q;
   assign btn_latch = btn_latch_q;
endmodule

// File: tb/tb_input_conditioner.sv
// tb_input_conditioner: scoreboard bench for input_conditioner with DEBOUNCE_CYCLES=8, SYNC_STAGES=2
module tb_input_conditioner;
   localparam int LAT = 10;

   typedef enum int {SW_DB, BTN_DB, IPIN_SYNC, BTN_RISE, BTN_FALL, BTN_LATCH} sig_e;
   typedef struct {
      int          cyc;
      string       tag;
      sig_e        sig;
      logic [31:0] mask;
      logic [31:0] exp;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [15:0] sw;
   logic [4:0]  btn, btn_clr, btn_db, btn_rise, btn_fall, btn_latch;
   logic [3:0]  ipin, ipin_sync;
   logic [15:0] sw_db;

   int   cyc = 0;
   int   n_checks = 0;
   int   n_fail = 0;
   exp_t sb[$];

   input_conditioner #(.DEBOUNCE_CYCLES(8), .SYNC_STAGES(2)) dut (
      .clk(clk), .rst_n(rst_n), .sw(sw), .btn(btn), .ipin(ipin), .btn_clr(btn_clr),
      .sw_db(sw_db), .btn_db(btn_db), .ipin_sync(ipin_sync),
      .btn_rise(btn_rise), .btn_fall(btn_fall), .btn_latch(btn_latch)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   function automatic logic [31:0] observe(input sig_e s);
      case (s)
         SW_DB:     return {16'h0, sw_db};
         BTN_DB:    return {27'h0, btn_db};
         IPIN_SYNC: return {28'h0, ipin_sync};
         BTN_RISE:  return {27'h0, btn_rise};
         BTN_FALL:  return {27'h0, btn_fall};
         default:   return {27'h0, btn_latch};
      endcase
   endfunction

   // expect (observed & mask) == exp after the k-th rising edge from now
   task automatic expect_at(input int k, input string tag, input sig_e s,
                            input logic [31:0] mask, input logic [31:0] exp);
      exp_t e;
      e.cyc = cyc + k; e.tag = tag; e.sig = s; e.mask = mask; e.exp = exp;
      sb.push_back(e);
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   always @(negedge clk) begin
      for (int i = sb.size() - 1; i >= 0; i--) begin
         if (sb[i].cyc == cyc) begin
            check(sb[i].tag, observe(sb[i].sig) & sb[i].mask, sb[i].exp);
            sb.delete(i);
         end
      end
   end

   initial begin
      rst_n = 1'b0; sw = 16'hFFFF; btn = 5'h1F; ipin = 4'h0; btn_clr = 5'h0;
      tick(1);
      // 1: outputs held at 0 in reset, then high inputs reported as rises
      expect_at(1, "rst_sw_db", SW_DB, 32'hFFFF, 0);
      expect_at(1, "rst_btn_db", BTN_DB, 32'h1F, 0);
      expect_at(1, "rst_ipin", IPIN_SYNC, 32'hF, 0);
      expect_at(1, "rst_rise", BTN_RISE, 32'h1F, 0);
      expect_at(1, "rst_fall", BTN_FALL, 32'h1F, 0);
      expect_at(1, "rst_latch", BTN_LATCH, 32'h1F, 0);
      tick(3);
      rst_n = 1'b1;
      expect_at(LAT-1, "rel_sw_early", SW_DB, 32'hFFFF, 0);
      expect_at(LAT-1, "rel_rise_early", BTN_RISE, 32'h1F, 0);
      expect_at(LAT, "rel_sw_db", SW_DB, 32'hFFFF, 32'hFFFF);
      expect_at(LAT, "rel_btn_db", BTN_DB, 32'h1F, 32'h1F);
      expect_at(LAT, "rel_rise", BTN_RISE, 32'h1F, 32'h1F);
      expect_at(LAT+1, "rel_rise_end", BTN_RISE, 32'h1F, 0);
      expect_at(LAT+1, "rel_latch", BTN_LATCH, 32'h1F, 32'h1F);
      tick(LAT+3);
      btn_clr = 5'h1F;
      expect_at(1, "clr_all", BTN_LATCH, 32'h1F, 0);
      tick(1);
      btn_clr = 5'h0; btn = 5'h0;
      expect_at(LAT, "rel_all_fall", BTN_FALL, 32'h1F, 32'h1F);
      expect_at(LAT, "rel_all_db", BTN_DB, 32'h1F, 0);
      expect_at(LAT+1, "rel_all_fall_end", BTN_FALL, 32'h1F, 0);
      tick(LAT+3);
      // 2: clean step on btn[0]
      btn[0] = 1'b1;
      expect_at(LAT-1, "step_db_early", BTN_DB, 32'h1, 0);
      expect_at(LAT, "step_db", BTN_DB, 32'h1, 32'h1);
      expect_at(LAT-1, "step_rise_early", BTN_RISE, 32'h1, 0);
      expect_at(LAT, "step_rise", BTN_RISE, 32'h1, 32'h1);
      expect_at(LAT+1, "step_rise_end", BTN_RISE, 32'h1, 0);
      expect_at(LAT, "step_fall", BTN_FALL, 32'h1F, 0);
      expect_at(LAT+1, "step_latch", BTN_LATCH, 32'h1, 32'h1);
      tick(LAT+3);
      btn[0] = 1'b0;
      expect_at(LAT, "step_fall0", BTN_FALL, 32'h1, 32'h1);
      tick(LAT+3);
      // 3: bounce on btn[2]
      btn[2] = 1'b1;
      expect_at(LAT, "bounce_db_hold", BTN_DB, 32'h4, 0);
      expect_at(LAT, "bounce_rise_hold", BTN_RISE, 32'h4, 0);
      tick(5);
      btn[2] = 1'b0;
      tick(1);
      btn[2] = 1'b1;
      expect_at(LAT-1, "bounce_db_early", BTN_DB, 32'h4, 0);
      expect_at(LAT-1, "bounce_rise_early", BTN_RISE, 32'h4, 0);
      expect_at(LAT, "bounce_db", BTN_DB, 32'h4, 32'h4);
      expect_at(LAT, "bounce_rise", BTN_RISE, 32'h4, 32'h4);
      expect_at(LAT+1, "bounce_rise_end", BTN_RISE, 32'h4, 0);
      tick(LAT+3);
      btn[2] = 1'b0;
      tick(LAT+3);
      // 4: sticky flag on btn[1], clear, then set/clear collision
      btn[1] = 1'b1;
      expect_at(LAT+1, "latch_set", BTN_LATCH, 32'h2, 32'h2);
      tick(LAT+3);
      btn_clr = 5'h2;
      expect_at(1, "latch_clr", BTN_LATCH, 32'h2, 0);
      tick(1);
      btn_clr = 5'h0; btn[1] = 1'b0;
      tick(LAT+3);
      btn_clr = 5'h2;
      expect_at(1, "clr_on_clear", BTN_LATCH, 32'h2, 0);
      tick(1);
      btn_clr = 5'h0; btn[1] = 1'b1;
      expect_at(LAT-1, "coll_before", BTN_LATCH, 32'h2, 0);
      expect_at(LAT, "coll_set_wins", BTN_LATCH, 32'h2, 32'h2);
      expect_at(LAT+1, "coll_stays", BTN_LATCH, 32'h2, 32'h2);
      tick(LAT-1);
      btn_clr = 5'h2;
      tick(1);
      btn_clr = 5'h0; btn[1] = 1'b0;
      tick(LAT+3);
      // 5: ipin fast path and btn[3] release
      ipin = 4'hA;
      expect_at(1, "ipin_early", IPIN_SYNC, 32'hF, 0);
      expect_at(2, "ipin_sync", IPIN_SYNC, 32'hF, 32'hA);
      btn[3] = 1'b1;
      tick(LAT+3);
      btn[3] = 1'b0;
      expect_at(LAT-1, "rel3_db_early", BTN_DB, 32'h8, 32'h8);
      expect_at(LAT, "rel3_db", BTN_DB, 32'h8, 0);
      expect_at(LAT-1, "rel3_fall_early", BTN_FALL, 32'h8, 0);
      expect_at(LAT, "rel3_fall", BTN_FALL, 32'h8, 32'h8);
      expect_at(LAT, "rel3_rise", BTN_RISE, 32'h8, 0);
      expect_at(LAT+1, "rel3_fall_end", BTN_FALL, 32'h8, 0);
      tick(LAT+3);
      // 6: reset asserted mid-count on sw[7]
      sw = 16'h0;
      expect_at(LAT, "sw_low", SW_DB, 32'hFFFF, 0);
      tick(LAT+3);
      sw[7] = 1'b1;
      expect_at(6, "mid_before_rst", SW_DB, 32'h80, 0);
      tick(6);
      rst_n = 1'b0;
      expect_at(1, "mid_in_rst", SW_DB, 32'h80, 0);
      expect_at(1, "mid_rst_latch", BTN_LATCH, 32'h1F, 0);
      expect_at(2, "mid_in_rst2", SW_DB, 32'h80, 0);
      tick(2);
      rst_n = 1'b1;
      expect_at(LAT-1, "mid_after_early", SW_DB, 32'h80, 0);
      expect_at(LAT, "mid_after", SW_DB, 32'h80, 32'h80);
      tick(LAT+3);
      check("sb_drain", sb.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
